// File: rtl/sub_test_pkg.sv
// Shared definitions for the radix-4 signed-digit subtractor test sequencer:
// digit geometry, vector widths, sequencer state encoding and small helpers.
package sub_test_pkg;

  localparam int DIGIT_W    = 3;
  localparam int N_DIGITS   = 6;
  localparam int RADIX      = 4;
  localparam int RES_DIGITS = N_DIGITS + 1;
  localparam int OP_W       = DIGIT_W * N_DIGITS;    // 18-bit operands
  localparam int RES_W      = DIGIT_W * RES_DIGITS;  // 21-bit results
  localparam int VAL_W      = 16;                    // holds +/-16383 with margin
  localparam int IDX_W      = 4;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = 5'd16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // Sign-extend one signed digit and scale it by RADIX^pos.
  function automatic logic signed [VAL_W-1:0] sd_digit_weight(
    input logic [DIGIT_W-1:0] digit,
    input int                 pos
  );
    logic signed [VAL_W-1:0] ext;
    ext = {{(VAL_W-DIGIT_W){digit[DIGIT_W-1]}}, digit};
    return ext <<< ($clog2(RADIX) * pos);
  endfunction

  // Counter increment that sticks at the maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + CNT_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/sd_value_r4.sv
// Combinational converter: a RES_DIGITS-long radix-4 signed-digit vector
// (digit 0 in the low bits) to its two's-complement value.
module sd_value_r4
  import sub_test_pkg::*;
(
  input  logic [RES_W-1:0]        i_digits,
  output logic signed [VAL_W-1:0] o_value
);

  logic signed [VAL_W-1:0] w_acc;

  // Accumulate digit_i * 4^i over all digits.
  always_comb begin
    w_acc = {VAL_W{1'b0}};
    for (int i = 0; i < RES_DIGITS; i++) begin
      w_acc = w_acc + sd_digit_weight(i_digits[i*DIGIT_W +: DIGIT_W], i);
    end
  end

  assign o_value = w_acc;

endmodule

// File: rtl/sub_test_sequencer_r4_n6.sv
// Run controller for the radix-4, 6-digit signed-digit subtractor: walks the
// vector ROM, hands each x/y pair to the DUT over valid/ready, collects the
// result and keeps pass/fail statistics for the run.
// Optional build macro SUB_SEQ_VALUE_CMP_EN: compare results by numeric value
// (two sd_value_r4 converters) so redundant digit encodings are accepted;
// without it the result must match the expected vector bit for bit.
module sub_test_sequencer_r4_n6
  import sub_test_pkg::*;
#(
  parameter int NUM_TESTS = 10,
  parameter int TIMEOUT   = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [IDX_W-1:0] o_test_select,
  input  logic [OP_W-1:0]  i_rom_x,
  input  logic [OP_W-1:0]  i_rom_y,
  input  logic [RES_W-1:0] i_rom_z,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  output logic [OP_W-1:0]  o_op_x,
  output logic [OP_W-1:0]  o_op_y,
  input  logic             i_res_valid,
  input  logic [RES_W-1:0] i_res_z,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_pass_count,
  output logic [CNT_W-1:0] o_fail_count,
  output logic [IDX_W-1:0] o_first_fail,
  output logic             o_timeout_flag
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] FF_NONE  = {IDX_W{1'b1}};

  seq_state_e       r_state,        w_state;
  logic [IDX_W-1:0] r_index,        w_index;
  logic [TMR_W-1:0] r_timer,        w_timer;
  logic [OP_W-1:0]  r_op_x,         w_op_x;
  logic [OP_W-1:0]  r_op_y,         w_op_y;
  logic [RES_W-1:0] r_exp_z,        w_exp_z;
  logic             r_op_valid,     w_op_valid;
  logic             r_busy,         w_busy;
  logic             r_done,         w_done;
  logic             r_pass,         w_pass;
  logic [CNT_W-1:0] r_pass_count,   w_pass_count;
  logic [CNT_W-1:0] r_fail_count,   w_fail_count;
  logic [IDX_W-1:0] r_first_fail,   w_first_fail;
  logic             r_timeout_flag, w_timeout_flag;

  logic w_match;
  logic w_verdict;
  logic w_failed;

`ifdef SUB_SEQ_VALUE_CMP_EN
  logic signed [VAL_W-1:0] w_res_value;
  logic signed [VAL_W-1:0] w_exp_value;

  sd_value_r4 u_res_value (
    .i_digits (i_res_z),
    .o_value  (w_res_value)
  );

  sd_value_r4 u_exp_value (
    .i_digits (r_exp_z),
    .o_value  (w_exp_value)
  );

  assign w_match = (w_res_value == w_exp_value);
`else
  assign w_match = (i_res_z == r_exp_z);
`endif

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    w_state        = r_state;
    w_index        = r_index;
    w_timer        = r_timer;
    w_op_x         = r_op_x;
    w_op_y         = r_op_y;
    w_exp_z        = r_exp_z;
    w_op_valid     = r_op_valid;
    w_busy         = r_busy;
    w_done         = 1'b0;
    w_pass         = r_pass;
    w_pass_count   = r_pass_count;
    w_fail_count   = r_fail_count;
    w_first_fail   = r_first_fail;
    w_timeout_flag = r_timeout_flag;
    w_verdict      = 1'b0;
    w_failed       = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_pass_count   = CNT_ZERO;
          w_fail_count   = CNT_ZERO;
          w_pass         = 1'b0;
          w_timeout_flag = 1'b0;
          w_first_fail   = FF_NONE;
          w_index        = IDX_ZERO;
          w_busy         = 1'b1;
          w_state        = LOAD;
        end else begin
          w_state = IDLE;
        end
      end

      LOAD: begin
        w_op_x     = i_rom_x;
        w_op_y     = i_rom_y;
        w_exp_z    = i_rom_z;
        w_op_valid = 1'b1;
        w_state    = ISSUE;
      end

      ISSUE: begin
        if (r_op_valid && i_op_ready) begin
          w_op_valid = 1'b0;
          w_timer    = TMR_ZERO;
          w_state    = WAIT;
        end else begin
          w_state = ISSUE;
        end
      end

      WAIT: begin
        // A result arriving on the expiry cycle wins over the timeout.
        if (i_res_valid) begin
          w_verdict = 1'b1;
          w_failed  = ~w_match;
        end else if (r_timer == TMR_LAST) begin
          w_verdict      = 1'b1;
          w_failed       = 1'b1;
          w_timeout_flag = 1'b1;
        end else begin
          w_timer = r_timer + TMR_ONE;
        end

        if (w_verdict) begin
          if (w_failed) begin
            w_fail_count = sat_inc(r_fail_count);
            if (r_fail_count == CNT_ZERO) begin
              w_first_fail = r_index;
            end else begin
              w_first_fail = r_first_fail;
            end
          end else begin
            w_pass_count = sat_inc(r_pass_count);
          end

          if (r_index == IDX_LAST) begin
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_pass  = (w_fail_count == CNT_ZERO);
            w_state = DONE;
          end else begin
            w_index = r_index + IDX_ONE;
            w_state = LOAD;
          end
        end else begin
          w_state = WAIT;
        end
      end

      DONE: begin
        w_state = IDLE;
      end

      default: begin
        w_op_valid = 1'b0;
        w_busy     = 1'b0;
        w_state    = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_index        <= IDX_ZERO;
      r_timer        <= TMR_ZERO;
      r_op_x         <= {OP_W{1'b0}};
      r_op_y         <= {OP_W{1'b0}};
      r_exp_z        <= {RES_W{1'b0}};
      r_op_valid     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_pass_count   <= CNT_ZERO;
      r_fail_count   <= CNT_ZERO;
      r_first_fail   <= FF_NONE;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_index        <= w_index;
      r_timer        <= w_timer;
      r_op_x         <= w_op_x;
      r_op_y         <= w_op_y;
      r_exp_z        <= w_exp_z;
      r_op_valid     <= w_op_valid;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_pass         <= w_pass;
      r_pass_count   <= w_pass_count;
      r_fail_count   <= w_fail_count;
      r_first_fail   <= w_first_fail;
      r_timeout_flag <= w_timeout_flag;
    end
  end

  assign o_test_select  = r_index;
  assign o_op_valid     = r_op_valid;
  assign o_op_x         = r_op_x;
  assign o_op_y         = r_op_y;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_pass_count   = r_pass_count;
  assign o_fail_count   = r_fail_count;
  assign o_first_fail   = r_first_fail;
  assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_sub_test_sequencer_r4_n6.sv
// Bench for sub_test_sequencer_r4_n6: plays the vector ROM and the subtractor,
// predicts each run's statistics from per-vector outcomes and checks them in
// a separate monitor process through scoreboard queues.
module tb_sub_test_sequencer_r4_n6;
  import sub_test_pkg::*;

  localparam int NT = 10;
  localparam int TO = 15;

  logic             clk;
  logic             i_rst, i_start, i_op_ready, i_res_valid;
  logic [IDX_W-1:0] o_test_select, o_first_fail;
  logic [OP_W-1:0]  i_rom_x, i_rom_y, o_op_x, o_op_y;
  logic [RES_W-1:0] i_rom_z, i_res_z;
  logic             o_op_valid, o_busy, o_done, o_pass, o_timeout_flag;
  logic [CNT_W-1:0] o_pass_count, o_fail_count;

  // ROM contents and per-vector DUT behaviour plan
  logic [OP_W-1:0]  rom_x [16];
  logic [OP_W-1:0]  rom_y [16];
  logic [RES_W-1:0] rom_z [16];
  logic [RES_W-1:0] mask  [16];
  int dly  [16];   // cycles op_ready stays low in ISSUE
  int lat  [16];   // result cycle after accept; 0 = never, >TO = too late
  int kind [16];   // 0 good, 1 corrupted bits, 2 redundant-zero case

  typedef struct { int pc; int fc; int ff; int tf; int cyc; } run_exp_t;
  typedef struct { int idx; logic [OP_W-1:0] x; logic [OP_W-1:0] y; } op_exp_t;

  run_exp_t run_q[$];
  op_exp_t  op_q[$];
  run_exp_t last_exp;

  int errors = 0;
  int checks = 0;

  assign i_rom_x = rom_x[o_test_select];
  assign i_rom_y = rom_y[o_test_select];
  assign i_rom_z = rom_z[o_test_select];

  sub_test_sequencer_r4_n6 #(.NUM_TESTS(NT), .TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .o_test_select  (o_test_select),
    .i_rom_x        (i_rom_x),
    .i_rom_y        (i_rom_y),
    .i_rom_z        (i_rom_z),
    .o_op_valid     (o_op_valid),
    .i_op_ready     (i_op_ready),
    .o_op_x         (o_op_x),
    .o_op_y         (o_op_y),
    .i_res_valid    (i_res_valid),
    .i_res_z        (i_res_z),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_pass_count   (o_pass_count),
    .o_fail_count   (o_fail_count),
    .o_first_fail   (o_first_fail),
    .o_timeout_flag (o_timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Numeric value of a 7-digit radix-4 signed-digit word
  function automatic int ref_value(input logic [RES_W-1:0] z);
    int v;
    int w;
    int d;
    v = 0;
    w = 1;
    for (int i = 0; i < RES_DIGITS; i++) begin
      d = int'(z[i*DIGIT_W +: DIGIT_W]);
      if (d >= 4) d = d - 8;
      v = v + d * w;
      w = w * 4;
    end
    return v;
  endfunction

  function automatic bit mism(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
`ifdef SUB_SEQ_VALUE_CMP_EN
    return ref_value(a) != ref_value(b);
`else
    return a != b;
`endif
  endfunction

  function automatic logic [RES_W-1:0] resp_of(input int v);
    logic [RES_W-1:0] r;
    case (kind[v])
      1:       r = rom_z[v] ^ mask[v];
      2:       r = 21'd0;
      default: r = rom_z[v];
    endcase
    return r;
  endfunction

  task automatic plan_base();
    for (int v = 0; v < 16; v++) begin
      rom_x[v] = 18'($urandom());
      rom_y[v] = 18'($urandom());
      rom_z[v] = 21'($urandom());
      mask[v]  = 21'd0;
      dly[v]   = 0;
      lat[v]   = 1;
      kind[v]  = 0;
    end
  endtask

  task automatic plan_random();
    int r;
    plan_base();
    for (int v = 0; v < NT; v++) begin
      dly[v] = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r == 0)      lat[v] = 0;
      else if (r == 1) lat[v] = TO + 1;
      else if (r == 2) lat[v] = TO;
      else             lat[v] = $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        kind[v] = 1;
        mask[v] = 21'($urandom_range(1, 2097151));
      end else if (r == 1) begin
        kind[v]  = 2;
        rom_z[v] = 21'h00C;  // digits {..,0,+1,-4}: value 0
      end
    end
  endtask

  // One run: push predictions, start, then play the DUT side per vector
  task automatic do_run(input int abort_vec);
    run_exp_t e;
    op_exp_t  o;
    int       w;
    int       n;
    bit       timed;
    bit       bad;
    e.pc = 0; e.fc = 0; e.ff = 15; e.tf = 0; e.cyc = 0;
    for (int v = 0; v < NT; v++) begin
      timed = (lat[v] == 0) || (lat[v] > TO);
      w     = timed ? TO : lat[v];
      bad   = timed || mism(resp_of(v), rom_z[v]);
      if (bad) begin
        e.fc++;
        if (e.ff == 15) e.ff = v;
      end else begin
        e.pc++;
      end
      if (timed) e.tf = 1;
      e.cyc += 1 + (dly[v] + 1) + w;
      if (abort_vec < 0 || v <= abort_vec) begin
        o.idx = v; o.x = rom_x[v]; o.y = rom_y[v];
        op_q.push_back(o);
      end
    end
    if (abort_vec < 0) begin
      run_q.push_back(e);
      last_exp = e;
    end

    i_start = 1'b1;
    tick();
    i_start = 1'b0;

    for (int v = 0; v < NT; v++) begin
      n = 0;
      while (!o_op_valid && n < 20) begin
        tick();
        n++;
      end
      chk("op_valid_wait", 32'(o_op_valid), 32'd1);
      if (!o_op_valid) break;
      for (int c = 0; c < dly[v]; c++) begin
        i_op_ready  = 1'b0;
        i_res_valid = 1'($urandom_range(0, 1));
        i_res_z     = 21'($urandom());
        i_start     = 1'($urandom_range(0, 1));
        tick();
      end
      i_res_valid = 1'b0;
      i_start     = 1'b0;
      i_op_ready  = 1'b1;
      tick();
      i_op_ready  = 1'b0;

      if (v == abort_vec) begin
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("abort_busy",     32'(o_busy),         32'd0);
        chk("abort_done",     32'(o_done),         32'd0);
        chk("abort_pass_cnt", 32'(o_pass_count),   32'd0);
        chk("abort_fail_cnt", 32'(o_fail_count),   32'd0);
        chk("abort_first",    32'(o_first_fail),   32'd15);
        chk("abort_tsel",     32'(o_test_select),  32'd0);
        chk("abort_opvalid",  32'(o_op_valid),     32'd0);
        chk("abort_tflag",    32'(o_timeout_flag), 32'd0);
        op_q.delete();
        repeat (20) tick();
        return;
      end

      w = ((lat[v] == 0) || (lat[v] > TO)) ? TO : lat[v];
      for (int c = 1; c <= w; c++) begin
        if (c == lat[v]) begin
          i_res_valid = 1'b1;
          i_res_z     = resp_of(v);
          i_op_ready  = 1'b0;
        end else begin
          i_res_valid = 1'b0;
          i_op_ready  = 1'($urandom_range(0, 1));
        end
        tick();
      end
      i_res_valid = 1'b0;
      i_op_ready  = 1'b0;
      if (lat[v] > TO) begin
        i_res_valid = 1'b1;
        i_res_z     = resp_of(v);
        tick();
        i_res_valid = 1'b0;
      end
    end

    n = 0;
    while (run_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("run_drain", 32'(run_q.size()), 32'd0);
    repeat (3) tick();
    chk("hold_busy",     32'(o_busy),         32'd0);
    chk("hold_pass",     32'(o_pass),         32'(last_exp.fc == 0));
    chk("hold_pass_cnt", 32'(o_pass_count),   32'(last_exp.pc));
    chk("hold_fail_cnt", 32'(o_fail_count),   32'(last_exp.fc));
    chk("hold_first",    32'(o_first_fail),   32'(last_exp.ff));
  endtask

  // Monitor: operand handshakes, ISSUE stability and end-of-run statistics
  int       busy_cnt  = 0;
  bit       prev_hold = 1'b0;
  bit       prev_done = 1'b0;
  logic [OP_W-1:0] hold_x, hold_y;
  initial begin
    run_exp_t e;
    op_exp_t  o;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        busy_cnt  = 0;
        prev_hold = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("issue_valid_stable", 32'(o_op_valid), 32'd1);
          chk("issue_x_stable",     32'(o_op_x),     32'(hold_x));
          chk("issue_y_stable",     32'(o_op_y),     32'(hold_y));
        end
        if (o_op_valid && i_op_ready) begin
          chk("op_expected", 32'(op_q.size() > 0), 32'd1);
          if (op_q.size() > 0) begin
            o = op_q.pop_front();
            chk("op_index", 32'(o_test_select), 32'(o.idx));
            chk("op_x",     32'(o_op_x),        32'(o.x));
            chk("op_y",     32'(o_op_y),        32'(o.y));
          end
        end
        prev_hold = o_op_valid && !i_op_ready;
        hold_x    = o_op_x;
        hold_y    = o_op_y;
        if (o_busy) busy_cnt++;
        if (o_done) begin
          chk("done_one_cycle", 32'(prev_done), 32'd0);
          chk("done_expected",  32'(run_q.size() > 0), 32'd1);
          if (run_q.size() > 0) begin
            e = run_q.pop_front();
            chk("done_busy",     32'(o_busy),         32'd0);
            chk("done_cycles",   32'(busy_cnt),       32'(e.cyc));
            chk("done_pass",     32'(o_pass),         32'(e.fc == 0));
            chk("done_pass_cnt", 32'(o_pass_count),   32'(e.pc));
            chk("done_fail_cnt", 32'(o_fail_count),   32'(e.fc));
            chk("done_first",    32'(o_first_fail),   32'(e.ff));
            chk("done_tflag",    32'(o_timeout_flag), 32'(e.tf));
          end
          busy_cnt = 0;
        end
        prev_done = o_done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_op_ready = 1'b0; i_res_valid = 1'b0; i_res_z = 21'd0;
    plan_base();
    repeat (3) tick();
    chk("rst_busy",     32'(o_busy),         32'd0);
    chk("rst_done",     32'(o_done),         32'd0);
    chk("rst_pass",     32'(o_pass),         32'd0);
    chk("rst_opvalid",  32'(o_op_valid),     32'd0);
    chk("rst_tsel",     32'(o_test_select),  32'd0);
    chk("rst_pass_cnt", 32'(o_pass_count),   32'd0);
    chk("rst_fail_cnt", 32'(o_fail_count),   32'd0);
    chk("rst_first",    32'(o_first_fail),   32'd15);
    chk("rst_tflag",    32'(o_timeout_flag), 32'd0);
    i_rst = 1'b0;
    tick();

    plan_base();                                  // ideal DUT
    do_run(-1);
    plan_base(); kind[4] = 1; mask[4] = 21'd1;     // LSB corrupted on vector 4
    do_run(-1);
    plan_base(); lat[7] = 0;                      // vector 7 never answers
    do_run(-1);
    plan_base();                                  // op_ready stalls every vector
    for (int v = 0; v < NT; v++) dly[v] = 5;
    do_run(-1);
    plan_base();                                  // reset during WAIT of vector 3
    do_run(3);
    plan_base(); kind[1] = 2; rom_z[1] = 21'h00C;  // redundant encoding of zero
    do_run(-1);
    plan_base(); lat[2] = TO; lat[5] = TO + 1;    // expiry-cycle result, late result
    do_run(-1);

    for (int r = 0; r < 12; r++) begin
      plan_random();
      do_run(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
